// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and imem.
//   req     fetch -> imem  one-cycle request pulse, addr valid the same cycle
//   addr    fetch -> imem  word-aligned fetch address
//   rvalid  imem -> fetch  read data valid (one or more cycles after req)
//   rdata   imem -> fetch  instruction word
interface fetch_unit_if;
    logic        req;
    logic [31:0] addr;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, output addr, input rvalid, input rdata);
    modport slave  (input req, input addr, output rvalid, output rdata);
endinterface

// File: rtl/fetch_unit.sv
// IF stage feeding fetch2decode. Holds the PC, keeps at most one imem request
// outstanding, buffers the returned word and presents it with pc+4 to IF/ID.
// Ports:
//   clk, rst      clock (posedge) and asynchronous active-high reset
//   stall_f       IF/ID holding: do not consume the buffered word
//   redirect_en   taken branch / jump from ID; redirect_pc is the target
//   imem          instruction-memory bus (master side)
//   instr         buffered word, or NOP_INSTR when instr_valid is low
//   pc_plus4      pc + 4 (32-bit wrap)
//   instr_valid   instr holds a real fetched word
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_f,
    input  logic              redirect_en,
    input  logic [31:0]       redirect_pc,
    fetch_unit_if.master      imem,
    output logic [31:0]       instr,
    output logic [31:0]       pc_plus4,
    output logic              instr_valid
);

    typedef enum logic [1:0] {
        IDLE,   // no request outstanding
        WAIT,   // one request outstanding
        FULL    // word buffered
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] buf_q, buf_d;
    logic        kill_q, kill_d;
    logic        req_c;
    logic [31:0] addr_c;
    logic [31:0] redirect_aligned;

    assign redirect_aligned = {redirect_pc[31:2], 2'b00};
    assign pc_plus4         = pc_q + 32'd4;
    assign instr_valid      = (state_q == FULL);
    assign instr            = (state_q == FULL) ? buf_q : NOP_INSTR;

    // State is already IDLE while rst is high, so the combinational request
    // would fire; gate it so no request leaves during reset.
    assign imem.req  = req_c & ~rst;
    assign imem.addr = addr_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            buf_q   <= NOP_INSTR;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            buf_q   <= buf_d;
            kill_q  <= kill_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        buf_d   = buf_q;
        kill_d  = kill_q;
        req_c   = 1'b0;
        addr_c  = pc_q;

        unique case (state_q)
            IDLE: begin
                if (redirect_en) begin
                    pc_d = redirect_aligned;
                end else begin
                    req_c   = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (redirect_en) begin
                    pc_d = redirect_aligned;
                end
                if (imem.rvalid) begin
                    if (kill_q || redirect_en) begin
                        // Response belongs to a path that was redirected away.
                        kill_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        buf_d   = imem.rdata;
                        state_d = FULL;
                    end
                end else if (redirect_en) begin
                    // Remember to drop the response still in flight.
                    kill_d = 1'b1;
                end
            end
            FULL: begin
                if (redirect_en) begin
                    pc_d    = redirect_aligned;
                    buf_d   = NOP_INSTR;
                    state_d = IDLE;
                end else if (!stall_f) begin
                    // Word consumed by IF/ID this edge; fetch the next one now.
                    pc_d    = pc_plus4;
                    req_c   = 1'b1;
                    addr_c  = pc_plus4;
                    state_d = WAIT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
